// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the mouse receiver and its companion transmitter.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } ps2_state_t;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_PARITY = 2'b01;
  localparam logic [1:0] ERR_FRAME  = 2'b10;

  // Inter-edge timeout: 2 ms at 100 MHz, shortened for simulation builds.
`ifdef SIMULATION
  localparam int PS2_TIMEOUT_CYCLES = 2_000;
`else
  localparam int PS2_TIMEOUT_CYCLES = 200_000;
`endif

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers on the raw PS/2 clock and data lines plus clock falling-edge detect.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall_edge
);

  logic [1:0] clk_sync;
  logic       clk_prev;
  logic       data_meta;

  // Everything resets to 1 so an idle bus never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      clk_prev  <= clk_sync[1];
      data_meta <= ps2_data;
      data_sync <= data_meta;
    end
  end

  assign fall_edge = clk_prev & ~clk_sync[1];

endmodule

// File: rtl/ps2_mouse_receiver.sv
// PS/2 device-to-host frame receiver feeding the mouse master state machine.
// state | meaning
// IDLE  | waiting for a start-bit edge while READ_ENABLE is high
// SHIFT | collecting bits 1..10; aborts on timeout or READ_ENABLE low
// DONE  | one cycle: BYTE_READY high, outputs just loaded
module ps2_mouse_receiver
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  ps2_state_t                  state;
  logic [3:0]                  bit_cnt;
  logic [TW-1:0]               timer;
  logic [PS2_FRAME_BITS-2:0]   shift_reg;
  logic                        data_sync;
  logic                        fall_edge;
  logic                        last_edge;
  logic                        parity_err;
  logic                        frame_err;

  ps2_sync_edge u_sync (
    .clk       (CLK),
    .rst_n     (RESET),
    .ps2_clk   (CLK_MOUSE_IN),
    .ps2_data  (DATA_MOUSE_IN),
    .data_sync (data_sync),
    .fall_edge (fall_edge)
  );

  // The stop bit is never stored: it is checked straight off the line on the final edge.
  assign last_edge  = (bit_cnt == 4'(PS2_FRAME_BITS - 1));
  assign parity_err = ~^shift_reg[9:1];
  assign frame_err  = shift_reg[0] | ~data_sync;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      timer           <= '0;
      shift_reg       <= '0;
      BYTE_READ       <= 8'h00;
      BYTE_ERROR_CODE <= ERR_NONE;
      BYTE_READY      <= 1'b0;
    end else begin
      BYTE_READY <= 1'b0;
      case (state)
        IDLE: begin
          bit_cnt <= '0;
          timer   <= '0;
          if (fall_edge && READ_ENABLE) begin
            shift_reg <= {{(PS2_FRAME_BITS-2){1'b0}}, data_sync};
            bit_cnt   <= 4'd1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (!READ_ENABLE) begin
            state   <= IDLE;
            bit_cnt <= '0;
            timer   <= '0;
          end else if (fall_edge) begin
            timer   <= '0;
            bit_cnt <= bit_cnt + 4'd1;
            if (last_edge) begin
              state           <= DONE;
              BYTE_READ       <= shift_reg[8:1];
              BYTE_ERROR_CODE <= (parity_err ? ERR_PARITY : ERR_NONE) |
                                 (frame_err  ? ERR_FRAME  : ERR_NONE);
              BYTE_READY      <= 1'b1;
            end else begin
              shift_reg[bit_cnt] <= data_sync;
            end
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            state   <= IDLE;
            bit_cnt <= '0;
            timer   <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          bit_cnt <= '0;
          timer   <= '0;
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          timer   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_mouse_receiver.sv
// Directed bench for ps2_mouse_receiver: 500 kHz CLK, 12.5 kHz PS/2 clock (20 CLK per half period).
`timescale 1ns/1ps
module tb_ps2_mouse_receiver;

  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       CLK_MOUSE_IN = 1'b1;
  logic       DATA_MOUSE_IN = 1'b1;
  logic       READ_ENABLE = 1'b0;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  int last_fall_cyc = 0;
  logic [7:0] log_byte [0:31];
  logic [1:0] log_err  [0:31];

  ps2_mouse_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .CLK_MOUSE_IN    (CLK_MOUSE_IN),
    .DATA_MOUSE_IN   (DATA_MOUSE_IN),
    .READ_ENABLE     (READ_ENABLE),
    .BYTE_READ       (BYTE_READ),
    .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
    .BYTE_READY      (BYTE_READY)
  );

  always #1000 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (BYTE_READY === 1'b1) begin
      log_byte[pulse_cnt % 32] = BYTE_READ;
      log_err[pulse_cnt % 32]  = BYTE_ERROR_CODE;
      pulse_cyc = cyc;
      pulse_cnt++;
    end
  end

  // frame layout: {stop, parity, data[7:0], start}, sent bit 0 first
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      DATA_MOUSE_IN = fr[i];
      repeat (HALF) @(negedge CLK);
      CLK_MOUSE_IN = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge CLK);
      CLK_MOUSE_IN = 1'b1;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    READ_ENABLE = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (BYTE_READ !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h expected 00", BYTE_READ); end
    checks++;
    if (BYTE_ERROR_CODE !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", BYTE_ERROR_CODE); end
    checks++;
    if (BYTE_READY !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", BYTE_READY); end
    RESET = 1'b1;
    READ_ENABLE = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if (pulse_cnt !== 0) begin errors++; $display("FAIL reset_pulses: got %0d expected 0", pulse_cnt); end
  endtask

  task automatic test_good_frame();
    int c0;
    c0 = pulse_cnt;
    send_bits({1'b1, 1'b1, 8'hFA, 1'b0}, 11);
    repeat (5) @(negedge CLK);
    checks++;
    if (pulse_cnt - c0 !== 1) begin errors++; $display("FAIL fa_pulses: got %0d expected 1", pulse_cnt - c0); end
    checks++;
    if (log_byte[c0 % 32] !== 8'hFA) begin errors++; $display("FAIL fa_byte: got %h expected fa", log_byte[c0 % 32]); end
    checks++;
    if (log_err[c0 % 32] !== 2'b00) begin errors++; $display("FAIL fa_err: got %b expected 00", log_err[c0 % 32]); end
    checks++;
    if (pulse_cyc - last_fall_cyc !== 3) begin errors++; $display("FAIL fa_latency: got %0d expected 3", pulse_cyc - last_fall_cyc); end
    repeat (30) @(negedge CLK);
    checks++;
    if (BYTE_READ !== 8'hFA || BYTE_READY !== 1'b0) begin
      errors++; $display("FAIL fa_hold: got byte %h ready %b expected fa 0", BYTE_READ, BYTE_READY);
    end
  endtask

  task automatic test_parity_error();
    int c0;
    c0 = pulse_cnt;
    send_bits({1'b1, 1'b0, 8'hAA, 1'b0}, 11);
    repeat (5) @(negedge CLK);
    checks++;
    if (pulse_cnt - c0 !== 1) begin errors++; $display("FAIL par_pulses: got %0d expected 1", pulse_cnt - c0); end
    checks++;
    if (log_byte[c0 % 32] !== 8'hAA) begin errors++; $display("FAIL par_byte: got %h expected aa", log_byte[c0 % 32]); end
    checks++;
    if (log_err[c0 % 32] !== 2'b01) begin errors++; $display("FAIL par_err: got %b expected 01", log_err[c0 % 32]); end
  endtask

  task automatic test_frame_error();
    int c0;
    c0 = pulse_cnt;
    send_bits({1'b0, 1'b1, 8'h00, 1'b0}, 11);
    repeat (5) @(negedge CLK);
    checks++;
    if (pulse_cnt - c0 !== 1) begin errors++; $display("FAIL frm_pulses: got %0d expected 1", pulse_cnt - c0); end
    checks++;
    if (log_byte[c0 % 32] !== 8'h00) begin errors++; $display("FAIL frm_byte: got %h expected 00", log_byte[c0 % 32]); end
    checks++;
    if (log_err[c0 % 32] !== 2'b10) begin errors++; $display("FAIL frm_err: got %b expected 10", log_err[c0 % 32]); end
  endtask

  task automatic test_timeout();
    int c0;
    c0 = pulse_cnt;
    send_bits({1'b1, 1'b0, 8'hF4, 1'b0}, 5);
    repeat (TO + 100) @(negedge CLK);
    checks++;
    if (pulse_cnt !== c0) begin errors++; $display("FAIL to_partial_pulses: got %0d expected %0d", pulse_cnt, c0); end
    checks++;
    if (BYTE_READ !== 8'h00 || BYTE_ERROR_CODE !== 2'b10) begin
      errors++; $display("FAIL to_outputs_held: got %h/%b expected 00/10", BYTE_READ, BYTE_ERROR_CODE);
    end
    send_bits({1'b1, 1'b0, 8'hF4, 1'b0}, 11);
    repeat (5) @(negedge CLK);
    checks++;
    if (pulse_cnt - c0 !== 1) begin errors++; $display("FAIL to_pulses: got %0d expected 1", pulse_cnt - c0); end
    checks++;
    if (log_byte[c0 % 32] !== 8'hF4) begin errors++; $display("FAIL to_byte: got %h expected f4", log_byte[c0 % 32]); end
    checks++;
    if (log_err[c0 % 32] !== 2'b00) begin errors++; $display("FAIL to_err: got %b expected 00", log_err[c0 % 32]); end
  endtask

  task automatic test_read_enable_drop();
    int c0;
    c0 = pulse_cnt;
    send_bits({1'b1, 1'b1, 8'h5D, 1'b0}, 4);
    READ_ENABLE = 1'b0;
    send_bits({1'b1, 1'b1, 8'h5D, 1'b0} >> 4, 7);
    repeat (5) @(negedge CLK);
    READ_ENABLE = 1'b1;
    repeat (5) @(negedge CLK);
    checks++;
    if (pulse_cnt !== c0 || BYTE_READ !== 8'hF4) begin
      errors++; $display("FAIL re_drop: got pulses %0d byte %h expected %0d f4", pulse_cnt, BYTE_READ, c0);
    end
  endtask

  task automatic test_reset_midframe();
    int c0;
    c0 = pulse_cnt;
    send_bits({1'b1, 1'b0, 8'h08, 1'b0}, 6);
    @(negedge CLK);
    #100 RESET = 1'b0;
    #10;
    checks++;
    if (BYTE_READ !== 8'h00 || BYTE_ERROR_CODE !== 2'b00 || BYTE_READY !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h/%b/%b expected 00/00/0", BYTE_READ, BYTE_ERROR_CODE, BYTE_READY);
    end
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    send_bits({1'b1, 1'b0, 8'h08, 1'b0}, 11);
    repeat (5) @(negedge CLK);
    checks++;
    if (pulse_cnt - c0 !== 1) begin errors++; $display("FAIL rst_mid_pulses: got %0d expected 1", pulse_cnt - c0); end
    checks++;
    if (log_byte[c0 % 32] !== 8'h08) begin errors++; $display("FAIL rst_mid_byte: got %h expected 08", log_byte[c0 % 32]); end
    checks++;
    if (log_err[c0 % 32] !== 2'b00) begin errors++; $display("FAIL rst_mid_err: got %b expected 00", log_err[c0 % 32]); end
  endtask

  task automatic test_back_to_back();
    int c0;
    logic [7:0] exp_b [0:2];
    exp_b[0] = 8'h08;
    exp_b[1] = 8'h01;
    exp_b[2] = 8'hFF;
    c0 = pulse_cnt;
    send_bits({1'b1, 1'b0, 8'h08, 1'b0}, 11);
    send_bits({1'b1, 1'b0, 8'h01, 1'b0}, 11);
    send_bits({1'b1, 1'b1, 8'hFF, 1'b0}, 11);
    repeat (5) @(negedge CLK);
    checks++;
    if (pulse_cnt - c0 !== 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", pulse_cnt - c0); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (log_byte[(c0 + k) % 32] !== exp_b[k]) begin
        errors++; $display("FAIL b2b_byte%0d: got %h expected %h", k, log_byte[(c0 + k) % 32], exp_b[k]);
      end
      checks++;
      if (log_err[(c0 + k) % 32] !== 2'b00) begin
        errors++; $display("FAIL b2b_err%0d: got %b expected 00", k, log_err[(c0 + k) % 32]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_frame_error();
    test_timeout();
    test_read_enable_drop();
    test_reset_midframe();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
